// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480 VGA timing constants and region helpers
package vga_timing_pkg;
  localparam int DEF_CLK_DIV = 4;
  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FP = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FP = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP = 29;
  localparam logic DEF_SYNC_ACTIVE = 1'b0;
  localparam int H_TOTAL = DEF_H_DISPLAY + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL = DEF_V_DISPLAY + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int H_SYNC_START = DEF_H_DISPLAY + DEF_H_FP;
  localparam int H_SYNC_END = H_SYNC_START + DEF_H_SYNC;
  localparam int V_SYNC_START = DEF_V_DISPLAY + DEF_V_FP;
  localparam int V_SYNC_END = V_SYNC_START + DEF_V_SYNC;
  function automatic logic inRange(input logic [9:0] value, input logic [9:0] lo, input logic [9:0] hi);
    return value >= lo && value < hi;
  endfunction
endpackage

// File: rtl/vga_sig_gen_counter.sv
// UGeneric_Counter: enable-gated wrapping counter with a terminal-count trigger
module UGeneric_Counter #(
  parameter int COUNTER_WIDTH = 10,
  parameter logic [COUNTER_WIDTH-1:0] COUNTER_MAX = '1
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     ENABLE_IN,
  output logic                     TRIG_OUT,
  output logic [COUNTER_WIDTH-1:0] COUNT
);
  assign TRIG_OUT = ENABLE_IN && COUNT == COUNTER_MAX;
  // count up on enable, wrapping to zero after COUNTER_MAX
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) COUNT <= '0;
    else if (ENABLE_IN) COUNT <= TRIG_OUT ? '0 : COUNT + 1'b1;
endmodule

// File: rtl/vga_sig_gen.sv
// vga_sig_gen: VGA timing generator with address output and aligned colour/sync pins
module vga_sig_gen
  import vga_timing_pkg::*;
#(
  parameter int   CLK_DIV     = DEF_CLK_DIV,
  parameter int   H_DISPLAY   = DEF_H_DISPLAY,
  parameter int   H_FP        = DEF_H_FP,
  parameter int   H_SYNC      = DEF_H_SYNC,
  parameter int   H_BP        = DEF_H_BP,
  parameter int   V_DISPLAY   = DEF_V_DISPLAY,
  parameter int   V_FP        = DEF_V_FP,
  parameter int   V_SYNC      = DEF_V_SYNC,
  parameter int   V_BP        = DEF_V_BP,
  parameter logic SYNC_ACTIVE = DEF_SYNC_ACTIVE
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [11:0] COLOUR_IN,
  output logic [9:0]  ADDRESS_H,
  output logic [8:0]  ADDRESS_V,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic [11:0] VGA_COLOUR,
  output logic        FRAME_START
);
  localparam int DIV_W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [9:0] hDisplay = 10'(H_DISPLAY);
  localparam logic [9:0] vDisplay = 10'(V_DISPLAY);
  localparam logic [9:0] hSyncStart = 10'(H_DISPLAY + H_FP);
  localparam logic [9:0] hSyncEnd = 10'(H_DISPLAY + H_FP + H_SYNC);
  localparam logic [9:0] vSyncStart = 10'(V_DISPLAY + V_FP);
  localparam logic [9:0] vSyncEnd = 10'(V_DISPLAY + V_FP + V_SYNC);
  localparam logic [9:0] hMax = 10'(H_DISPLAY + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] vMax = 10'(V_DISPLAY + V_FP + V_SYNC + V_BP - 1);
  logic [DIV_W-1:0] unusedDivCount;
  logic [9:0] hCount, vCount;
  logic pixelTick, hWrap, vWrap;
  logic hVisible, vVisible, visibleD, hSyncD, vSyncD;
  UGeneric_Counter #(.COUNTER_WIDTH(DIV_W), .COUNTER_MAX(DIV_W'(CLK_DIV - 1))) uPixelDiv (
    .CLK(CLK), .RESET(RESET), .ENABLE_IN(1'b1), .TRIG_OUT(pixelTick), .COUNT(unusedDivCount)
  );
  UGeneric_Counter #(.COUNTER_WIDTH(10), .COUNTER_MAX(hMax)) uHCount (
    .CLK(CLK), .RESET(RESET), .ENABLE_IN(pixelTick), .TRIG_OUT(hWrap), .COUNT(hCount)
  );
  UGeneric_Counter #(.COUNTER_WIDTH(10), .COUNTER_MAX(vMax)) uVCount (
    .CLK(CLK), .RESET(RESET), .ENABLE_IN(hWrap), .TRIG_OUT(vWrap), .COUNT(vCount)
  );
  assign hVisible = hCount < hDisplay;
  assign vVisible = vCount < vDisplay;
  // address stage: publish the current pixel and remember its region for the pin stage
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      ADDRESS_H <= '0;
      ADDRESS_V <= '0;
      visibleD <= 1'b0;
      hSyncD <= 1'b0;
      vSyncD <= 1'b0;
    end else if (pixelTick) begin
      ADDRESS_H <= hVisible ? hCount : '0;
      ADDRESS_V <= vVisible ? vCount[8:0] : '0;
      visibleD <= hVisible && vVisible;
      hSyncD <= inRange(hCount, hSyncStart, hSyncEnd);
      vSyncD <= inRange(vCount, vSyncStart, vSyncEnd);
    end
  // pin stage: colour returned for the previous address, with sync from the same pixel
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      VGA_COLOUR <= '0;
      VGA_HS <= ~SYNC_ACTIVE;
      VGA_VS <= ~SYNC_ACTIVE;
    end else if (pixelTick) begin
      VGA_COLOUR <= visibleD ? COLOUR_IN : '0;
      VGA_HS <= hSyncD ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      VGA_VS <= vSyncD ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end
  // one-CLK frame marker following the edge where both counters wrap
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) FRAME_START <= 1'b0;
    else FRAME_START <= vWrap;
endmodule

// File: tb/tb_vga_sig_gen.sv
// tb_vga_sig_gen: directed checks of VGA timing, addressing, blanking and mid-frame reset
module tb_vga_sig_gen;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic [11:0] colourIn = '0;
  logic [9:0] ADDRESS_H;
  logic [8:0] ADDRESS_V;
  logic VGA_HS, VGA_VS, FRAME_START;
  logic [11:0] VGA_COLOUR;
  logic useModel = 1'b1;
  int checks = 0;
  int failures = 0;
  int edges = 0;
  int fsCount = 0;

  // full-size horizontal timing; vertical shrunk to 10 lines (visible 0..3, sync lines 6..7)
  vga_sig_gen #(.V_DISPLAY(4), .V_FP(2), .V_SYNC(2), .V_BP(2)) dut (
    .CLK(CLK), .RESET(RESET), .COLOUR_IN(colourIn), .ADDRESS_H(ADDRESS_H), .ADDRESS_V(ADDRESS_V),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_COLOUR(VGA_COLOUR), .FRAME_START(FRAME_START)
  );

  always #5 CLK = ~CLK;

  // colour stage model: registered lookup of the address, or a constant white
  always @(posedge CLK) colourIn <= useModel ? {2'b00, ADDRESS_H} : 12'hFFF;

  always @(negedge CLK) if (FRAME_START === 1'b1) fsCount++;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic goTo(input int e);
    while (edges < e) begin
      @(posedge CLK);
      edges++;
    end
    #1;
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_addr_h", 32'(ADDRESS_H), 0);
    chk("rst_addr_v", 32'(ADDRESS_V), 0);
    chk("rst_hs", 32'(VGA_HS), 1);
    chk("rst_vs", 32'(VGA_VS), 1);
    chk("rst_colour", 32'(VGA_COLOUR), 0);
    chk("rst_frame", 32'(FRAME_START), 0);
    @(negedge CLK);
    RESET = 1'b0;
    edges = 0;
    goTo(7);    chk("tick_pre_h", 32'(ADDRESS_H), 0);
    goTo(8);    chk("tick2_h", 32'(ADDRESS_H), 1);
    goTo(408);  chk("colour_px100", 32'(VGA_COLOUR), 32'h064);
    goTo(2560); chk("addr_h_639", 32'(ADDRESS_H), 639);
    goTo(2564); chk("addr_h_640", 32'(ADDRESS_H), 0);
    chk("colour_px639", 32'(VGA_COLOUR), 32'h27F);
    useModel = 1'b0;
    goTo(2631); chk("hs_pre", 32'(VGA_HS), 1);
    goTo(2632); chk("hs_fall", 32'(VGA_HS), 0);
    chk("colour_hblank", 32'(VGA_COLOUR), 0);
    goTo(3015); chk("hs_last", 32'(VGA_HS), 0);
    goTo(3016); chk("hs_rise", 32'(VGA_HS), 1);
    goTo(3204); chk("addr_v_line1", 32'(ADDRESS_V), 1);
    goTo(3248); chk("colour_white", 32'(VGA_COLOUR), 32'hFFF);
    goTo(5831); chk("hs2_pre", 32'(VGA_HS), 1);
    goTo(5832); chk("hs2_fall", 32'(VGA_HS), 0);
    goTo(9624); chk("addr_v_line3", 32'(ADDRESS_V), 3);
    chk("addr_h_line3", 32'(ADDRESS_H), 5);
    goTo(12824); chk("addr_v_line4", 32'(ADDRESS_V), 0);
    chk("addr_h_line4", 32'(ADDRESS_H), 5);
    goTo(16048); chk("colour_vblank", 32'(VGA_COLOUR), 0);
    goTo(19207); chk("vs_pre", 32'(VGA_VS), 1);
    goTo(19208); chk("vs_fall", 32'(VGA_VS), 0);
    goTo(25607); chk("vs_last", 32'(VGA_VS), 0);
    goTo(25608); chk("vs_rise", 32'(VGA_VS), 1);
    goTo(31999); chk("fs_pre", 32'(FRAME_START), 0);
    goTo(32000); chk("fs_pulse", 32'(FRAME_START), 1);
    goTo(32001); chk("fs_post", 32'(FRAME_START), 0);
    goTo(32002); chk("fs_count", 32'(fsCount), 1);
    goTo(32048); chk("colour_frame2", 32'(VGA_COLOUR), 32'hFFF);
    goTo(41204); chk("mid_hs", 32'(VGA_HS), 0);
    chk("mid_addr_v", 32'(ADDRESS_V), 2);
    #2 RESET = 1'b1;
    #1;
    chk("async_hs", 32'(VGA_HS), 1);
    chk("async_vs", 32'(VGA_VS), 1);
    chk("async_addr_v", 32'(ADDRESS_V), 0);
    chk("async_colour", 32'(VGA_COLOUR), 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    edges = 0;
    goTo(8);     chk("re_tick2_h", 32'(ADDRESS_H), 1);
    goTo(2631);  chk("re_hs_pre", 32'(VGA_HS), 1);
    goTo(2632);  chk("re_hs_fall", 32'(VGA_HS), 0);
    goTo(19207); chk("re_vs_pre", 32'(VGA_VS), 1);
    goTo(19208); chk("re_vs_fall", 32'(VGA_VS), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
